// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU add sequencer.
//   DATA_W   datapath width
//   op_e     request opcodes (ADD/SUB/ADC/MUL)
//   state_e  sequencer FSM states
package alu_pkg;

    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_MUL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_MUL  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/adder16_cin.sv
// adder16_cin: 16-bit ripple-carry adder with carry-in.
// Ports:
//   x, y  in   addends
//   cin   in   carry into bit 0
//   sum   out  x + y + cin, modulo 2^16
//   c16   out  carry out of bit 15
//   c15   out  carry into bit 15 (for signed-overflow detection)
module adder16_cin
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              c16,
    output logic              c15
);

    logic [DATA_W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            sum[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        c16 = c[DATA_W];
        c15 = c[DATA_W-1];
    end

endmodule

// File: rtl/alu_add_sequencer.sv
// alu_add_sequencer: drives the single adder16_cin to execute ADD, SUB, ADC
// and (optionally) 16-iteration shift-add unsigned MUL.
// Configuration macro: ALU_SEQ_MUL_EN
//   defined   - op 11 runs MUL, op_err is always 0
//   undefined - op 11 returns zeros with op_err=1; no MUL counter/hi register
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   request handshake (ready only in IDLE)
//   op, a, b            opcode and operands, latched on accept
//   out_valid/out_ready result handshake; outputs held until accepted
//   res_lo, res_hi      result (res_hi only non-zero for MUL)
//   flag_v/c/n/z        overflow, carry, true sign, zero
//   op_err              request was not executable
module alu_add_sequencer
    import alu_pkg::*;
#(
    parameter logic        CARRY_RST = 1'b0,
    parameter int unsigned MUL_ITERS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] res_lo,
    output logic [DATA_W-1:0] res_hi,
    output logic              flag_v,
    output logic              flag_c,
    output logic              flag_n,
    output logic              flag_z,
    output logic              op_err
);

    if (MUL_ITERS != DATA_W) begin : g_iters_chk
        $error("alu_add_sequencer: MUL_ITERS must equal 16");
    end

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic              carry_q, carry_d;
    logic [DATA_W-1:0] res_lo_q, res_lo_d;
    logic              flag_v_q, flag_v_d, flag_c_q, flag_c_d;
    logic              flag_n_q, flag_n_d, flag_z_q, flag_z_d;
    logic              op_err_q, op_err_d;

`ifdef ALU_SEQ_MUL_EN
    localparam int unsigned CNT_W = $clog2(MUL_ITERS + 1);
    logic [DATA_W-1:0] res_hi_q, res_hi_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mul_acc;
    logic              mul_c;
`endif

    logic [DATA_W-1:0] add_x, add_y, add_sum;
    logic              add_cin, add_c16, add_c15;
    logic              add_v;

    adder16_cin u_adder (
        .x   (add_x),
        .y   (add_y),
        .cin (add_cin),
        .sum (add_sum),
        .c16 (add_c16),
        .c15 (add_c15)
    );

    assign add_v = add_c16 ^ add_c15;

    // Adder operand steering: MUL iterations add A into the hi accumulator,
    // otherwise the latched opcode selects the ADD/SUB/ADC form.
    always_comb begin
        add_x   = a_q;
        add_y   = b_q;
        add_cin = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        if (state_q == ST_MUL) begin
            add_x = res_hi_q;
            add_y = a_q;
        end else
`endif
        begin
            case (op_q)
                OP_SUB: begin
                    add_y   = ~b_q;
                    add_cin = 1'b1;
                end
                OP_ADC:  add_cin = carry_q;
                default: add_cin = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        res_lo_d = res_lo_q;
        flag_v_d = flag_v_q;
        flag_c_d = flag_c_q;
        flag_n_d = flag_n_q;
        flag_z_d = flag_z_q;
        op_err_d = op_err_q;
`ifdef ALU_SEQ_MUL_EN
        res_hi_d = res_hi_q;
        cnt_d    = cnt_q;
        mul_c    = 1'b0;
        mul_acc  = res_hi_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d    = op_e'(op);
                    a_d     = a;
                    b_d     = b;
                    state_d = ST_EXEC;
`ifdef ALU_SEQ_MUL_EN
                    if (op_e'(op) == OP_MUL) begin
                        res_hi_d = '0;
                        res_lo_d = b;
                        cnt_d    = '0;
                        state_d  = ST_MUL;
                    end
`endif
                end
            end
            ST_EXEC: begin
                state_d  = ST_DONE;
                op_err_d = 1'b0;
`ifdef ALU_SEQ_MUL_EN
                res_hi_d = '0;
`endif
                if (op_q == OP_MUL) begin
                    // Only reachable without MUL support: report an error, keep carry.
                    res_lo_d = '0;
                    flag_v_d = 1'b0;
                    flag_c_d = 1'b0;
                    flag_n_d = 1'b0;
                    flag_z_d = 1'b0;
                    op_err_d = 1'b1;
                end else begin
                    res_lo_d = add_sum;
                    flag_v_d = add_v;
                    flag_c_d = add_c16;
                    flag_n_d = add_sum[DATA_W-1] ^ add_v;
                    flag_z_d = (add_sum == '0);
                    carry_d  = add_c16;
                end
            end
            ST_MUL: begin
`ifdef ALU_SEQ_MUL_EN
                if (res_lo_q[0]) begin
                    mul_c   = add_c16;
                    mul_acc = add_sum;
                end
                res_hi_d = {mul_c, mul_acc[DATA_W-1:1]};
                res_lo_d = {mul_acc[0], res_lo_q[DATA_W-1:1]};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(MUL_ITERS - 1)) begin
                    state_d  = ST_DONE;
                    op_err_d = 1'b0;
                    flag_c_d = (res_hi_d != '0);
                    flag_v_d = (res_hi_d != '0);
                    flag_n_d = res_hi_d[DATA_W-1];
                    flag_z_d = ({res_hi_d, res_lo_d} == '0);
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= CARRY_RST;
            res_lo_q <= '0;
            flag_v_q <= 1'b0;
            flag_c_q <= 1'b0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
            op_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            res_lo_q <= res_lo_d;
            flag_v_q <= flag_v_d;
            flag_c_q <= flag_c_d;
            flag_n_q <= flag_n_d;
            flag_z_q <= flag_z_d;
            op_err_q <= op_err_d;
        end
    end

`ifdef ALU_SEQ_MUL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_hi_q <= '0;
            cnt_q    <= '0;
        end else begin
            res_hi_q <= res_hi_d;
            cnt_q    <= cnt_d;
        end
    end
    assign res_hi = res_hi_q;
`else
    assign res_hi = '0;
`endif

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign res_lo    = res_lo_q;
    assign flag_v    = flag_v_q;
    assign flag_c    = flag_c_q;
    assign flag_n    = flag_n_q;
    assign flag_z    = flag_z_q;
    assign op_err    = op_err_q;

endmodule

// File: tb/tb_alu_add_sequencer.sv
// tb_alu_add_sequencer: scoreboard bench for alu_add_sequencer.
// Honours ALU_SEQ_MUL_EN the same way as the design.
module tb_alu_add_sequencer;

    localparam logic [1:0] T_ADD = 2'b00;
    localparam logic [1:0] T_SUB = 2'b01;
    localparam logic [1:0] T_ADC = 2'b10;
    localparam logic [1:0] T_MUL = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic        out_valid, out_ready;
    logic [15:0] res_lo, res_hi;
    logic        flag_v, flag_c, flag_n, flag_z, op_err;

    alu_add_sequencer #(.CARRY_RST(1'b0), .MUL_ITERS(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_lo    (res_lo),
        .res_hi    (res_hi),
        .flag_v    (flag_v),
        .flag_c    (flag_c),
        .flag_n    (flag_n),
        .flag_z    (flag_z),
        .op_err    (op_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] hi;
        logic [15:0] lo;
        logic        v, c, n, z, err;
        int unsigned lat;
        int unsigned acc_cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic        model_carry = 1'b0;

    always @(posedge clk) cyc++;

    // Reference: evaluate the true mathematical result, then derive flags from it.
    function automatic exp_t model(input logic [1:0] o, input logic [15:0] x,
                                   input logic [15:0] y, input logic cin);
        exp_t        e;
        int          sx, sy, st;
        int unsigned ux, uy;
        longint unsigned p;
        sx = int'($signed(x));
        sy = int'($signed(y));
        ux = int'(x);
        uy = int'(y);
        e.hi = '0; e.lo = '0; e.v = 0; e.c = 0; e.n = 0; e.z = 0; e.err = 0;
        e.lat = 2; e.acc_cyc = 0;
        st = 0;
        case (o)
            T_ADD: begin st = sx + sy;       e.c = (ux + uy > 65535); end
            T_SUB: begin st = sx - sy;       e.c = (ux >= uy); end
            T_ADC: begin st = sx + sy + int'(cin); e.c = (ux + uy + int'(cin) > 65535); end
            default: ;
        endcase
        if (o != T_MUL) begin
            e.lo = st[15:0];
            e.v  = (st > 32767) || (st < -32768);
            e.n  = (st < 0);
            e.z  = (e.lo == 16'h0000);
        end else begin
`ifdef ALU_SEQ_MUL_EN
            p    = longint'(x) * longint'(y);
            e.hi = p[31:16];
            e.lo = p[15:0];
            e.c  = (e.hi != 0);
            e.v  = (e.hi != 0);
            e.n  = e.hi[15];
            e.z  = (p == 0);
            e.lat = 17;
`else
            p     = 0;
            e.err = 1'b1;
`endif
        end
        return e;
    endfunction

    // Monitor: compares every presented result cycle against the queue head.
    bit seen = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            seen = 0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_result: got out_valid=1, required no result pending");
            end else begin
                e = sb[0];
                if (!seen) begin
                    checks++;
                    if (cyc - e.acc_cyc != e.lat) begin
                        errors++;
                        $display("FAIL latency: got %0d edges, required %0d", cyc - e.acc_cyc, e.lat);
                    end
                    seen = 1;
                end
                checks++;
                if ({res_hi, res_lo, flag_v, flag_c, flag_n, flag_z, op_err} !==
                    {e.hi, e.lo, e.v, e.c, e.n, e.z, e.err}) begin
                    errors++;
                    $display("FAIL result: got hi=%h lo=%h vcnz=%b%b%b%b err=%b, required hi=%h lo=%h vcnz=%b%b%b%b err=%b",
                             res_hi, res_lo, flag_v, flag_c, flag_n, flag_z, op_err,
                             e.hi, e.lo, e.v, e.c, e.n, e.z, e.err);
                end
                if (out_ready) begin
                    void'(sb.pop_front());
                    seen = 0;
                end
            end
        end
    end

    task automatic check1(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({in_ready, out_valid, res_hi, res_lo, flag_v, flag_c, flag_n, flag_z, op_err} !==
            {1'b1, 1'b0, 16'h0, 16'h0, 5'b0}) begin
            errors++;
            $display("FAIL %s: got rdy=%b vld=%b hi=%h lo=%h flags=%b%b%b%b err=%b, required rdy=1 vld=0 all else 0",
                     name, in_ready, out_valid, res_hi, res_lo, flag_v, flag_c, flag_n, flag_z, op_err);
        end
    endtask

    task automatic do_req(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        bit   ok = 0;
        in_valid = 1'b1; op = o; a = x; b = y;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (in_ready) begin
                e = model(o, x, y, model_carry);
                e.acc_cyc = cyc;
                if (o != T_MUL) model_carry = e.c;
                sb.push_back(e);
                ok = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no accept, required accept within 100 cycles");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        logic [1:0] ro;
        rst = 1'b1; in_valid = 1'b0; op = 2'b00; a = '0; b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset_state");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // 1. async reset in the middle of a long operation
        out_ready = 1'b0;
        do_req(T_MUL, 16'h1234, 16'h5678);
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        sb.delete();
        model_carry = 1'b0;
        #1 check_reset_outputs("reset_mid_op");
        @(posedge clk); #1 check_reset_outputs("reset_next_cycle");
        @(negedge clk) rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        do_req(T_ADC, 16'h0000, 16'h0000);   // exposes CARRY_RST
        do_req(T_ADD, 16'h0001, 16'h0001);
        drain();

        // 2-4. directed arithmetic corners
        do_req(T_ADD, 16'h7FFF, 16'h0001);
        do_req(T_SUB, 16'h0000, 16'h0001);
        do_req(T_SUB, 16'h1234, 16'h1234);
        do_req(T_ADD, 16'hFFFF, 16'h0001);
        do_req(T_ADC, 16'h0000, 16'h0000);
        do_req(T_ADC, 16'h8000, 16'h8000);
        do_req(T_ADC, 16'h0000, 16'h0000);

        // 5. MUL (or op_err path), carry must survive it
        do_req(T_ADD, 16'hFFFF, 16'h0001);
        do_req(T_MUL, 16'hFFFF, 16'hFFFF);
        do_req(T_ADC, 16'h0000, 16'h0000);
        do_req(T_MUL, 16'h0003, 16'h0005);
        do_req(T_MUL, 16'h0000, 16'hBEEF);
        drain();

        // 6. backpressure with a waiting request
        out_ready = 1'b0;
        do_req(T_ADD, 16'h4000, 16'h4000);
        in_valid = 1'b1; op = T_SUB; a = 16'h0005; b = 16'h0009;
        repeat (6) begin
            @(posedge clk); #1;
            check1("bp_in_ready_low", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check1("bp_idle_after_release", in_ready, 1'b1);
        do_req(T_SUB, 16'h0005, 16'h0009);
        drain();

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            ro = 2'($urandom_range(0, 3));
            do_req(ro, 16'($urandom), 16'($urandom));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got simulation still running, required completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
